// File: rtl/product_accumulator_if.sv
// Valid/ready bundle between the multiplier stage, the product accumulator
// and the downstream consumer of completed dot-product results.
`timescale 1ns/1ps

interface product_accumulator_if #(
    parameter int PW = 8,
    parameter int AW = 12
);
    logic          p_valid;
    logic          p_ready;
    logic [PW-1:0] p_data;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic          res_ovf;

    // Producer/consumer side: offers products and takes results
    modport master (
        output p_valid, p_data, res_ready,
        input  p_ready, res_valid, res_data, res_ovf
    );

    // Accumulator side: takes products and offers results
    modport slave (
        input  p_valid, p_data, res_ready,
        output p_ready, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums LEN consecutive unsigned products into one saturating dot-product
// result, then holds that result on a valid/ready port until it is taken.
`timescale 1ns/1ps

module product_accumulator #(
    parameter int PW  = 8,
    parameter int AW  = 12,
    parameter int LEN = 4,
    localparam int CW = $clog2(LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    product_accumulator_if.slave  bus,
    output logic [CW-1:0]         term_cnt,
    output logic                  busy
);
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] acc, acc_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          ovf, ovf_next;
    logic [AW:0]   sum;
    logic          accept;

    // The extra top bit of sum catches the carry that triggers saturation
    assign sum    = {1'b0, acc} + (AW+1)'(bus.p_data);
    assign accept = bus.p_valid & bus.p_ready;

    assign bus.p_ready   = (state == ACC) & ~clear & ~rst;
    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = acc;
    assign bus.res_ovf   = ovf;
    assign term_cnt      = cnt;
    assign busy          = (cnt != '0) | (state == DONE);

    // State register; reset wins over everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    // Next-state logic: clear aborts, otherwise accumulate in ACC or wait for the result handshake in DONE
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        if (clear) begin
            state_next = ACC;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (accept) begin
                        if (sum[AW]) begin
                            acc_next = '1;
                            ovf_next = 1'b1;
                        end else begin
                            acc_next = sum[AW-1:0];
                        end
                        cnt_next = cnt + 1'b1;
                        if (cnt == CW'(LEN - 1)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_next = ACC;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = ACC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 12-bit and a 9-bit accumulator see the
// same inputs and are compared against a saturating-sum reference model.
`timescale 1ns/1ps

module tb_product_accumulator;
    localparam int LEN = 4;
    localparam int CW  = $clog2(LEN) + 1;
    localparam int MAX12 = 4095;
    localparam int MAX9  = 511;

    logic          clk;
    logic          rst;
    logic          clear;
    logic [CW-1:0] term_cnt12, term_cnt9;
    logic          busy12, busy9;

    int tests_run  = 0;
    int fail_count = 0;

    // Reference model state
    bit m_done;
    int m_cnt;
    int m_acc12, m_acc9;
    bit m_ovf12, m_ovf9;

    product_accumulator_if #(.PW(8), .AW(12)) bus12 ();
    product_accumulator_if #(.PW(8), .AW(9))  bus9 ();

    product_accumulator #(.PW(8), .AW(12), .LEN(LEN)) dut12 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bus      (bus12),
        .term_cnt (term_cnt12),
        .busy     (busy12)
    );

    product_accumulator #(.PW(8), .AW(9), .LEN(LEN)) dut9 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bus      (bus9),
        .term_cnt (term_cnt9),
        .busy     (busy9)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic addProduct(inout int acc, inout bit ovf, input int p, input int maxv);
        if (acc + p > maxv) begin
            acc = maxv;
            ovf = 1'b1;
        end else begin
            acc = acc + p;
        end
    endtask

    task automatic modelReset();
        m_done  = 1'b0;
        m_cnt   = 0;
        m_acc12 = 0;
        m_acc9  = 0;
        m_ovf12 = 1'b0;
        m_ovf9  = 1'b0;
    endtask

    task automatic modelStep(input bit r, input bit c, input bit v, input logic [7:0] d, input bit rr);
        if (r || c) begin
            modelReset();
        end else if (m_done) begin
            if (rr) modelReset();
        end else if (v) begin
            addProduct(m_acc12, m_ovf12, int'(d), MAX12);
            addProduct(m_acc9, m_ovf9, int'(d), MAX9);
            m_cnt++;
            if (m_cnt == LEN) m_done = 1'b1;
        end
    endtask

    task automatic checkOutput();
        bit exp_ready;
        exp_ready = !m_done && !clear && !rst;
        checkValue("p_ready12", 32'(bus12.p_ready), 32'(exp_ready));
        checkValue("p_ready9", 32'(bus9.p_ready), 32'(exp_ready));
        checkValue("res_valid12", 32'(bus12.res_valid), 32'(m_done));
        checkValue("res_valid9", 32'(bus9.res_valid), 32'(m_done));
        checkValue("res_data12", 32'(bus12.res_data), 32'(m_acc12));
        checkValue("res_data9", 32'(bus9.res_data), 32'(m_acc9));
        checkValue("res_ovf12", 32'(bus12.res_ovf), 32'(m_ovf12));
        checkValue("res_ovf9", 32'(bus9.res_ovf), 32'(m_ovf9));
        checkValue("term_cnt12", 32'(term_cnt12), 32'(m_cnt));
        checkValue("term_cnt9", 32'(term_cnt9), 32'(m_cnt));
        checkValue("busy12", 32'(busy12), 32'(m_cnt != 0 || m_done));
        checkValue("busy9", 32'(busy9), 32'(m_cnt != 0 || m_done));
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit v, input logic [7:0] d, input bit rr);
        rst             = r;
        clear           = c;
        bus12.p_valid   = v;
        bus9.p_valid    = v;
        bus12.p_data    = d;
        bus9.p_data     = d;
        bus12.res_ready = rr;
        bus9.res_ready  = rr;
        @(posedge clk);
        modelStep(r, c, v, d, rr);
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic beat(input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic handshake();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        logic [7:0] prods [4];
        prods[0] = 8'd6;
        prods[1] = 8'd15;
        prods[2] = 8'd225;
        prods[3] = 8'd0;

        rst = 1'b1;
        clear = 1'b0;
        bus12.p_valid = 1'b0; bus9.p_valid = 1'b0;
        bus12.p_data = '0;    bus9.p_data = '0;
        bus12.res_ready = 1'b0; bus9.res_ready = 1'b0;
        modelReset();

        // Reset held two cycles under random inputs
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), 1'($urandom_range(0, 1)));
        end
        idle();
        checkValue("reset_p_ready", 32'(bus12.p_ready), 32'd1);
        checkValue("reset_res_data", 32'(bus12.res_data), 32'd0);
        checkValue("reset_busy", 32'(busy12), 32'd0);

        // Back-to-back beats
        for (int i = 0; i < 4; i++) begin
            beat(prods[i]);
            checkValue("b2b_term_cnt", 32'(term_cnt12), 32'(i + 1));
        end
        checkValue("b2b_res_valid", 32'(bus12.res_valid), 32'd1);
        checkValue("b2b_res_data", 32'(bus12.res_data), 32'd246);
        checkValue("b2b_p_ready", 32'(bus12.p_ready), 32'd0);

        // Backpressure with a pending product upstream
        for (int i = 0; i < 5; i++) begin
            beat(8'd7);
            checkValue("stall_res_data", 32'(bus12.res_data), 32'd246);
            checkValue("stall_term_cnt", 32'(term_cnt12), 32'd4);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd7, 1'b1);
        checkValue("hs_res_valid", 32'(bus12.res_valid), 32'd0);
        checkValue("hs_p_ready", 32'(bus12.p_ready), 32'd1);
        checkValue("hs_acc", 32'(bus12.res_data), 32'd0);
        beat(8'd7);
        checkValue("post_hs_term_cnt", 32'(term_cnt12), 32'd1);
        checkValue("post_hs_res_data", 32'(bus12.res_data), 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Gapped input with garbage data on idle cycles
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
            end
            beat(prods[i]);
        end
        checkValue("gap_res_data", 32'(bus12.res_data), 32'd246);
        handshake();

        // Saturation on the narrow accumulator
        for (int i = 0; i < 3; i++) beat(8'd225);
        checkValue("sat_acc9", 32'(bus9.res_data), 32'd511);
        checkValue("sat_ovf9", 32'(bus9.res_ovf), 32'd1);
        checkValue("sat_acc12", 32'(bus12.res_data), 32'd675);
        beat(8'd1);
        checkValue("sat_final9", 32'(bus9.res_data), 32'd511);
        checkValue("sat_final_ovf9", 32'(bus9.res_ovf), 32'd1);
        checkValue("sat_final12", 32'(bus12.res_data), 32'd676);
        handshake();
        checkValue("sat_ovf_cleared", 32'(bus9.res_ovf), 32'd0);

        // Clear with a beat offered after two accepts
        beat(8'd10);
        beat(8'd20);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd30, 1'b0);
        checkValue("clr_term_cnt", 32'(term_cnt12), 32'd0);
        checkValue("clr_res_data", 32'(bus12.res_data), 32'd0);

        // Clear while holding a result
        for (int i = 0; i < 4; i++) beat(8'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkValue("clr_done_res_valid", 32'(bus12.res_valid), 32'd0);

        // Reset and clear together mid-accumulation
        beat(8'd99);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd5, 1'b1);
        idle();

        // Reset while holding a result with the consumer ready
        for (int i = 0; i < 4; i++) beat(8'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd44, 1'b1);
        checkValue("rst_done_res_valid", 32'(bus12.res_valid), 32'd0);
        checkValue("rst_done_term_cnt", 32'(term_cnt12), 32'd0);

        // Random traffic with occasional aborts
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 24) == 0),
                          1'($urandom_range(0, 2) != 0), 8'($urandom),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Sequential stage directly downstream of the 4x4 combinational array multiplier. It takes one 8-bit product per handshake beat and sums LEN consecutive products into a dot-product result. The result is held on a valid/ready output port until the consumer takes it. The multiplier output connects to p_data; the control FSM or an external pin drives p_valid.

Parameters:
PW, 8, product input width; matches the multiplier output.
AW, 12, accumulator and result width; at least PW.
LEN, 4, products per result; at least 2.
CW (localparam), clog2(LEN)+1, width of term_cnt.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
clear  input  1  synchronous abort; discards the partial sum
p_valid  input  1  a product is offered on p_data
p_ready  output  1  block accepts a product this cycle
p_data  input  PW  unsigned product
res_valid  output  1  completed sum available
res_ready  input  1  consumer takes the result
res_data  output  AW  accumulator value; meaningful only while res_valid=1
res_ovf  output  1  sticky saturation flag for the current result
term_cnt  output  CW  products accepted toward the current result
busy  output  1  1 when term_cnt!=0 or res_valid=1

Behaviour:
- Clocking and reset: single clock domain. All state is registered and updates only on the rising edge of clk.
- Reset (rst=1, sampled on the clock edge): state=ACC, acc=0, term_cnt=0, res_ovf=0, res_valid=0. Outputs after reset: p_ready=1, res_data=0, busy=0.
- Priority per cycle: rst, then clear, then the normal handshake.
- States:
  - ACC: collecting products.
  - DONE: result held.
- p_ready is combinational: p_ready = (state==ACC) & ~clear & ~rst.
- Accept event: p_valid & p_ready.
- ACC, on accept:
  - sum = acc + zero-extend(p_data), computed with width AW+1.
  - If sum[AW]=1: acc <= all ones, res_ovf <= 1 (saturate).
  - Otherwise: acc <= sum[AW-1:0].
  - term_cnt <= term_cnt+1.
- ACC, on the accept where term_cnt==LEN-1: next state DONE, res_valid <= 1, term_cnt <= LEN. Result latency is 1 cycle after the LEN-th accept.
- ACC, no accept: all state holds. Idle gaps between beats are allowed.
- DONE:
  - res_valid=1 and p_ready=0.
  - res_data and res_ovf stay stable until the handshake.
  - p_valid is ignored; any offered beat stays pending upstream.
- DONE, on res_valid & res_ready: next cycle state=ACC, acc=0, term_cnt=0, res_ovf=0, res_valid=0, p_ready=1. There is no same-cycle bypass: a product offered during the handshake cycle is not accepted.
- res_data = acc at all times. The partial sum is visible in ACC but is not valid.
- clear=1 in any state: next cycle same as the reset values.
  - A beat offered in that cycle is dropped (p_ready=0).
  - A held result is discarded without a handshake.
- Arithmetic: unsigned only. Saturation is sticky until the result handshake or clear. Once acc is saturated it stays at all ones.
- No X propagation: p_data is don't-care when p_valid=0, and acc must not change in that case.

Test Plan:
1. Reset: hold rst 2 cycles with random inputs -> p_ready=1, res_valid=0, res_data=0, res_ovf=0, term_cnt=0, busy=0.
2. Back-to-back beats with defaults, products 6, 15, 225, 0 (from 3x2, 5x3, 15x15, 0x9) -> term_cnt 1, 2, 3, 4; the cycle after the 4th accept res_valid=1, res_data=246, res_ovf=0, p_ready=0.
3. Backpressure after scenario 2: res_ready=0 for 5 cycles while p_valid=1 with p_data=7.
   - Required during the stall: res_data stays 246, the beat is not accepted, term_cnt stays 4.
   - Then res_ready=1 for one cycle: next cycle res_valid=0, p_ready=1, acc=0; the following accept of 7 gives term_cnt=1, res_data=7.
4. Gapped input: the products of scenario 2 with 0-3 idle cycles between beats and p_data=8'hFF during idle cycles -> identical result 246; acc unchanged during gaps.
5. Saturation with AW=9: products 225, 225, 225, 1 -> acc after beat 3 is 511, res_ovf=1; final res_data=511, res_ovf=1. After the handshake res_ovf=0.
6. Abort cases:
   - clear after 2 accepted beats, in the same cycle as p_valid=1 -> beat dropped; next cycle term_cnt=0, res_data=0.
   - clear while in DONE -> res_valid=0 next cycle.
   - rst and clear together -> same as reset.
   - rst in DONE with res_ready=1 -> no handshake side effects; reset values result.
